// File: rtl/rvh_noc_pkg.sv
// Shared NoC router types and limits used by the switch-allocation logic.
package rvh_noc_pkg;

  localparam int VC_DEPTH_MAX    = 2;
  localparam int QoS_Value_Width = 4;
  localparam int VC_ID_NUM_MAX_W = 2;
  localparam int SA_AGE_MAX      = 15;

  typedef struct packed {
    logic                       vld;
    logic [VC_ID_NUM_MAX_W-1:0] vc_id;
    logic [QoS_Value_Width-1:0] qos_value;
  } sa_req_t;

endpackage

// File: rtl/rvh_noc_qos_rr_picker.sv
// Combinational picker: highest QoS among eligible requesters, ties broken
// by the first index at or after rr_ptr in circular order.
module rvh_noc_qos_rr_picker #(
  parameter int REQ_NUM = 4,
  parameter int QOS_W   = 4,
  parameter int IDX_W   = 2
) (
  input  logic [REQ_NUM-1:0]       eligible,
  input  logic [REQ_NUM*QOS_W-1:0] eff_qos,
  input  logic [IDX_W-1:0]         rr_ptr,
  output logic [REQ_NUM-1:0]       win_oh,
  output logic [IDX_W-1:0]         win_idx
);

  logic             found;
  logic [QOS_W-1:0] best;
  int               idx;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    best    = '0;
    idx     = 0;
    // Strict '>' keeps the earliest circular candidate on a tie.
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (eligible[idx] && (!found || (eff_qos[idx*QOS_W +: QOS_W] > best))) begin
        found   = 1'b1;
        best    = eff_qos[idx*QOS_W +: QOS_W];
        win_idx = IDX_W'(idx);
      end
    end
    if (found) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/rvh_noc_output_port_credit_arbiter.sv
// Output-port switch allocator: QoS/round-robin/aging arbitration gated by
// per-VC downstream credit counters.
module rvh_noc_output_port_credit_arbiter
  import rvh_noc_pkg::*;
#(
  parameter int REQ_NUM  = 4,
  parameter int VC_NUM   = 4,
  parameter int VC_DEPTH = VC_DEPTH_MAX,
  parameter int QOS_W    = QoS_Value_Width,
  parameter int AGE_MAX  = SA_AGE_MAX,
  localparam int VC_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int IDX_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  localparam int CNT_W   = $clog2(VC_DEPTH + 1),
  localparam int AGE_W   = $clog2(AGE_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [REQ_NUM-1:0]       req_vld_i,
  input  logic [REQ_NUM*VC_W-1:0]  req_vc_id_i,
  input  logic [REQ_NUM*QOS_W-1:0] req_qos_i,
  output logic                     grant_vld_o,
  output logic [REQ_NUM-1:0]       grant_oh_o,
  output logic [VC_W-1:0]          grant_vc_id_o,
  input  logic                     credit_ret_vld_i,
  input  logic [VC_W-1:0]          credit_ret_vc_id_i,
  output logic [VC_NUM-1:0]        credit_avail_o,
  output logic                     credit_err_o
);

  localparam int VC_PAD = 1 << VC_ID_NUM_MAX_W;

  logic [CNT_W-1:0]         credit_cnt     [VC_NUM];
  logic [CNT_W-1:0]         credit_cnt_nxt [VC_NUM];
  logic [AGE_W-1:0]         age            [REQ_NUM];
  logic [IDX_W-1:0]         rr_ptr;
  logic                     err_set;
  sa_req_t                  req            [REQ_NUM];
  logic [VC_PAD-1:0]        avail_pad;
  logic [REQ_NUM-1:0]       eligible;
  logic [REQ_NUM*QOS_W-1:0] eff_qos;
  logic [REQ_NUM-1:0]       win_oh;
  logic [IDX_W-1:0]         win_idx;

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) credit_avail_o[v] = (credit_cnt[v] != '0);
  end

  // VC ids beyond VC_NUM land on zero bits of avail_pad and are never eligible.
  always_comb begin
    avail_pad = '0;
    for (int v = 0; v < VC_NUM; v++) avail_pad[v] = credit_avail_o[v];
    for (int i = 0; i < REQ_NUM; i++) begin
      req[i].vld       = req_vld_i[i];
      req[i].vc_id     = VC_ID_NUM_MAX_W'(req_vc_id_i[i*VC_W +: VC_W]);
      req[i].qos_value = QoS_Value_Width'(req_qos_i[i*QOS_W +: QOS_W]);
      eligible[i]      = req[i].vld && avail_pad[req[i].vc_id];
      eff_qos[i*QOS_W +: QOS_W] = (age[i] == AGE_W'(AGE_MAX)) ? {QOS_W{1'b1}}
                                                               : QOS_W'(req[i].qos_value);
    end
  end

  rvh_noc_qos_rr_picker #(
    .REQ_NUM (REQ_NUM),
    .QOS_W   (QOS_W),
    .IDX_W   (IDX_W)
  ) u_picker (
    .eligible (eligible),
    .eff_qos  (eff_qos),
    .rr_ptr   (rr_ptr),
    .win_oh   (win_oh),
    .win_idx  (win_idx)
  );

  assign grant_vld_o   = rstn && (|eligible);
  assign grant_oh_o    = rstn ? win_oh : '0;
  assign grant_vc_id_o = req_vc_id_i[win_idx*VC_W +: VC_W];

  // Grant and return on the same VC cancel; a return at full depth saturates.
  always_comb begin
    err_set = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      credit_cnt_nxt[v] = credit_cnt[v];
      if (credit_ret_vld_i && (credit_ret_vc_id_i == VC_W'(v))) begin
        if (!(grant_vld_o && (grant_vc_id_o == VC_W'(v)))) begin
          if (credit_cnt[v] == CNT_W'(VC_DEPTH)) err_set = 1'b1;
          else credit_cnt_nxt[v] = credit_cnt[v] + 1'b1;
        end
      end else if (grant_vld_o && (grant_vc_id_o == VC_W'(v))) begin
        credit_cnt_nxt[v] = credit_cnt[v] - 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the credit and age arrays are small register files that must
      // restart from known values, so each entry is reset explicitly.
      for (int v = 0; v < VC_NUM; v++) credit_cnt[v] <= CNT_W'(VC_DEPTH);
      for (int i = 0; i < REQ_NUM; i++) age[i] <= '0;
      rr_ptr       <= '0;
      credit_err_o <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) credit_cnt[v] <= credit_cnt_nxt[v];
      if (err_set) credit_err_o <= 1'b1;
      if (grant_vld_o)
        rr_ptr <= (win_idx == IDX_W'(REQ_NUM - 1)) ? '0 : win_idx + 1'b1;
      for (int i = 0; i < REQ_NUM; i++) begin
        if (!req_vld_i[i] || grant_oh_o[i]) age[i] <= '0;
        else if (age[i] != AGE_W'(AGE_MAX)) age[i] <= age[i] + 1'b1;
      end
    end
  end

endmodule
